// File: rtl/mem_pkg.sv
// mem_pkg: FSM state encoding and default sizes shared by mem_req_ctrl and its bench.
package mem_pkg;
    typedef enum logic [2:0] {IDLE, WRITE, READ, CAPTURE, RESP} state_e;
    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 8;
    localparam int MEM_DEPTH = 2 ** ADDR_W_DEF;
endpackage

// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: single-outstanding-request memory controller.
// Define MEM_REQ_CTRL_VERIFY_EN to read back every write and flag a mismatch on rsp_err.
module mem_req_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              Clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              mem_wr,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);
`ifdef MEM_REQ_CTRL_VERIFY_EN
    localparam bit VERIFY_EN = 1'b1;
`else
    localparam bit VERIFY_EN = 1'b0;
`endif

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    always_ff @(posedge Clk) begin
        if (!rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (req_valid) begin
                state_d = req_we ? WRITE : READ;
                we_d    = req_we;
                addr_d  = req_addr;
                wdata_d = req_wdata;
                rdata_d = '0;
                err_d   = 1'b0;
            end
            WRITE:   state_d = VERIFY_EN ? READ : RESP;
            READ:    state_d = CAPTURE;
            CAPTURE: begin
                state_d = RESP;
                rdata_d = mem_rdata;
                // err stays 0 on plain reads and in the non-verify build
                err_d   = VERIFY_EN && we_q && (mem_rdata != wdata_q);
            end
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign req_ready = state_q == IDLE;
    assign busy      = state_q != IDLE;
    assign rsp_valid = state_q == RESP;
    assign mem_wr    = state_q == WRITE;
    assign mem_rd    = state_q == READ;
    assign mem_addr  = (mem_wr || mem_rd) ? addr_q : '0;
    assign mem_wdata = mem_wr ? wdata_q : '0;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
endmodule

// File: tb/tb_mem_req_ctrl.sv
// tb_mem_req_ctrl: directed checks of mem_req_ctrl against a synchronous-read memory model.
module tb_mem_req_ctrl;
    import mem_pkg::*;

    logic       Clk = 1'b0;
    logic       rst = 1'b0;
    logic       req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
    logic [3:0] req_addr = '0;
    logic [7:0] req_wdata = '0;
    logic       req_ready, rsp_valid, rsp_err, mem_wr, mem_rd, busy;
    logic [7:0] rsp_rdata, mem_wdata, mem_rdata, mem_q;
    logic [3:0] mem_addr;
    logic       force_zero = 1'b0;
    logic [7:0] mem_arr [MEM_DEPTH];
    int n_checks = 0, n_fail = 0;
    int wr_cnt = 0, rd_cnt = 0, both_cnt = 0;
    logic [3:0] last_waddr = '0;
    logic [7:0] last_wdata = '0;
    int lat, w0, r0, v;

    mem_req_ctrl dut (
        .Clk(Clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        if (mem_wr) begin
            mem_arr[mem_addr] <= mem_wdata;
            wr_cnt = wr_cnt + 1;
            last_waddr = mem_addr;
            last_wdata = mem_wdata;
        end
        if (mem_rd) begin
            mem_q <= mem_arr[mem_addr];
            rd_cnt = rd_cnt + 1;
        end
        if (mem_wr && mem_rd) both_cnt = both_cnt + 1;
    end
    assign mem_rdata = force_zero ? 8'h00 : mem_q;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where rsp_valid is seen (or budget expires).
    task automatic do_req(input logic we, input logic [3:0] a, input logic [7:0] d, output int l);
        int t = 0;
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        while (!req_ready && t < 20) begin @(negedge Clk); t++; end
        @(posedge Clk);
        l = 1;
        @(negedge Clk);
        req_valid = 1'b0; req_we = ~we; req_addr = ~a; req_wdata = ~d;
        while (!rsp_valid && l < 10) begin @(negedge Clk); l++; end
    endtask

    task automatic rsp_ack();
        rsp_ready = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_strobes", {mem_wr, mem_rd}, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_err", rsp_err, 0);
        rst = 1'b1;

        w0 = wr_cnt;
        do_req(1'b1, 4'd0, 8'hAA, lat);
`ifdef MEM_REQ_CTRL_VERIFY_EN
        check("wr_aa_lat", lat, 4);
`else
        check("wr_aa_lat", lat, 2);
`endif
        check("wr_aa_busy", busy, 1);
        check("wr_aa_count", wr_cnt - w0, 1);
        check("wr_aa_addr", last_waddr, 0);
        check("wr_aa_data", last_wdata, 8'hAA);
        rsp_ack();

        check("b2b_ready", req_ready, 1);
        w0 = wr_cnt; r0 = rd_cnt;
        do_req(1'b0, 4'd0, 8'h00, lat);
        check("rd_aa_lat", lat, 3);
        check("rd_aa_data", rsp_rdata, 8'hAA);
        check("rd_aa_err", rsp_err, 0);
        check("rd_aa_rd_count", rd_cnt - r0, 1);
        check("rd_aa_wr_count", wr_cnt - w0, 0);
        rsp_ack();

        do_req(1'b1, 4'd1, 8'hBB, lat);
        rsp_ack();
        do_req(1'b0, 4'd1, 8'h00, lat);
        check("bp_lat", lat, 3);
        w0 = wr_cnt; r0 = rd_cnt;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            check("bp_valid", rsp_valid, 1);
            check("bp_data", rsp_rdata, 8'hBB);
            check("bp_ready", req_ready, 0);
        end
        check("bp_strobes", (wr_cnt - w0) + (rd_cnt - r0), 0);
        rsp_ack();

        do_req(1'b1, 4'd2, 8'hCC, lat);
        check("wr_cc_addr", last_waddr, 2);
        check("wr_cc_data", last_wdata, 8'hCC);
`ifndef MEM_REQ_CTRL_VERIFY_EN
        check("wr_cc_rdata_zero", rsp_rdata, 0);
`endif
        rsp_ack();
        do_req(1'b0, 4'd2, 8'h00, lat);
        check("rd_cc_data", rsp_rdata, 8'hCC);
        rsp_ack();

        req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd2;
        @(posedge Clk);
        @(negedge Clk);
        req_valid = 1'b0;
        check("abort_in_read", mem_rd, 1);
        rst = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        rst = 1'b1;
        check("abort_busy", busy, 0);
        check("abort_ready", req_ready, 1);
        check("abort_strobes", {mem_wr, mem_rd}, 0);
        v = 0;
        for (int i = 0; i < 4; i++) begin
            if (rsp_valid) v++;
            @(negedge Clk);
        end
        check("abort_no_rsp", v, 0);
        do_req(1'b0, 4'd2, 8'h00, lat);
        check("abort_reread", rsp_rdata, 8'hCC);
        rsp_ack();

        do_req(1'b1, 4'd15, 8'h5A, lat);
`ifdef MEM_REQ_CTRL_VERIFY_EN
        check("vfy_lat", lat, 4);
        check("vfy_rdata", rsp_rdata, 8'h5A);
`else
        check("vfy_lat", lat, 2);
        check("vfy_rdata", rsp_rdata, 0);
`endif
        check("vfy_err", rsp_err, 0);
        rsp_ack();
        force_zero = 1'b1;
        do_req(1'b1, 4'd14, 8'h5A, lat);
`ifdef MEM_REQ_CTRL_VERIFY_EN
        check("vfy_bad_err", rsp_err, 1);
`else
        check("vfy_bad_err", rsp_err, 0);
`endif
        check("vfy_bad_rdata", rsp_rdata, 0);
        rsp_ack();
        force_zero = 1'b0;

        check("no_overlap", both_cnt, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
